// File: rtl/ss_pkg.sv
// Shared types and constants for the SS result buffer.
package ss_pkg;

  localparam int DATA_W    = 40;
  localparam int FRAME_2X2 = 4;
  localparam int FRAME_4X4 = 16;

  // One buffered result together with its end-of-frame marker.
  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } ss_entry_t;

endpackage

// File: rtl/ss_fifo.sv
// Generic synchronous FIFO of ss_entry_t.
// - Exact occupancy counter.
// - Push while full is accepted only together with a pop.
// - A pop on an empty FIFO is ignored, so there is no fall-through.
// - The head entry is read combinationally and reads as zero while empty.
module ss_fifo
  import ss_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  ss_entry_t                i_wdata,
  output ss_entry_t                o_rdata,
  output logic                     o_empty,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  ss_entry_t        r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_empty;
  logic             w_full;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_empty   = (r_count == CNT_W'(0));
  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign w_do_pop  = i_pop && !w_empty;
  assign w_do_push = i_push && (!w_full || w_do_pop);

  // Storage write; memory contents need no reset because reads are gated by empty.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= PTR_W'(0);
      r_rd_ptr <= PTR_W'(0);
      r_count  <= CNT_W'(0);
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Head-of-queue view, forced to zero while there is nothing to show.
  always_comb begin
    o_rdata = '0;
    if (!w_empty) begin
      o_rdata = r_mem[r_rd_ptr];
    end else begin
      o_rdata = '0;
    end
  end

  assign o_empty = w_empty;
  assign o_full  = w_full;
  assign o_count = r_count;

endmodule

// File: rtl/ss_result_buffer.sv
// Captures the non-backpressurable SS result stream into a FIFO.
// - Replays the results over ready/valid, marking the last result of each frame.
// - Reports the per-frame maximum.
// - Keeps a sticky flag when a result has to be dropped.
// Frame alignment and the maximum follow every strobe, including dropped ones.
module ss_result_buffer #(
  parameter int DATA_W = 40,
  parameter int DEPTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    matrix_size,
  input  logic                    in_valid,
  input  logic [DATA_W-1:0]       in_value,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       out_data,
  output logic                    out_last,
  output logic [DATA_W-1:0]       frame_max,
  output logic                    frame_max_valid,
  output logic                    overflow,
  output logic [$clog2(DEPTH):0]  count
);

  import ss_pkg::*;

  localparam logic [3:0] LAST_2X2 = 4'(FRAME_2X2 - 1);
  localparam logic [3:0] LAST_4X4 = 4'(FRAME_4X4 - 1);

  logic [3:0]        r_idx;
  logic              r_size_4x4;
  logic [DATA_W-1:0] r_run_max;
  logic [DATA_W-1:0] r_frame_max;
  logic              r_frame_max_valid;
  logic              r_overflow;

  logic              w_size_4x4;
  logic              w_last;
  logic [DATA_W-1:0] w_new_max;
  logic              w_drop;
  logic              w_empty;
  logic              w_full;
  ss_entry_t         w_wr_entry;
  ss_entry_t         w_rd_entry;

  // Frame size comes from matrix_size only on the first result; later changes are ignored.
  always_comb begin
    w_size_4x4 = r_size_4x4;
    w_last     = 1'b0;
    w_new_max  = r_run_max;
    if (r_idx == 4'd0) begin
      w_size_4x4 = matrix_size;
    end else begin
      w_size_4x4 = r_size_4x4;
    end
    if (w_size_4x4) begin
      w_last = (r_idx == LAST_4X4);
    end else begin
      w_last = (r_idx == LAST_2X2);
    end
    if (in_value > r_run_max) begin
      w_new_max = in_value;
    end else begin
      w_new_max = r_run_max;
    end
  end

  // Frame position, running maximum and the completed-frame maximum pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx             <= 4'd0;
      r_size_4x4        <= 1'b0;
      r_run_max         <= {DATA_W{1'b0}};
      r_frame_max       <= {DATA_W{1'b0}};
      r_frame_max_valid <= 1'b0;
    end else begin
      r_frame_max_valid <= 1'b0;
      if (in_valid) begin
        r_size_4x4 <= w_size_4x4;
        if (w_last) begin
          r_idx             <= 4'd0;
          r_run_max         <= {DATA_W{1'b0}};
          r_frame_max       <= w_new_max;
          r_frame_max_valid <= 1'b1;
        end else begin
          r_idx     <= r_idx + 4'd1;
          r_run_max <= w_new_max;
        end
      end
    end
  end

  // A full FIFO can always pop, so a strobe is lost only when the consumer stalls.
  assign w_drop = in_valid && w_full && !out_ready;

  // Sticky drop indicator, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end
  end

  assign w_wr_entry.last = w_last;
  assign w_wr_entry.data = in_value;

  ss_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (in_valid),
    .i_pop   (out_ready),
    .i_wdata (w_wr_entry),
    .o_rdata (w_rd_entry),
    .o_empty (w_empty),
    .o_full  (w_full),
    .o_count (count)
  );

  assign out_valid       = !w_empty;
  assign out_data        = w_rd_entry.data;
  assign out_last        = w_rd_entry.last;
  assign frame_max       = r_frame_max;
  assign frame_max_valid = r_frame_max_valid;
  assign overflow        = r_overflow;

endmodule

// File: tb/tb_ss_result_buffer.sv
// Self-checking bench for ss_result_buffer: a table for the basic 2x2 frame,
// a scoreboard queue for the stream, and hand-written multi-cycle sequences.
module tb_ss_result_buffer;

  localparam int DW = 40;
  localparam int DEPTH = 16;

  logic          clk;
  logic          rst;
  logic          matrix_size;
  logic          in_valid;
  logic [DW-1:0] in_value;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic [DW-1:0] frame_max;
  logic          frame_max_valid;
  logic          overflow;
  logic [4:0]    count;

  ss_result_buffer #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst             (rst),
    .matrix_size     (matrix_size),
    .in_valid        (in_valid),
    .in_value        (in_value),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_data        (out_data),
    .out_last        (out_last),
    .frame_max       (frame_max),
    .frame_max_valid (frame_max_valid),
    .overflow        (overflow),
    .count           (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic          last;
    logic [DW-1:0] data;
  } sb_t;

  typedef struct {
    logic          iv;
    logic [DW-1:0] val;
    logic          ms;
    logic          rdy;
    logic          e_ov;
    logic [DW-1:0] e_data;
    logic          e_last;
    logic          e_fmv;
    logic [DW-1:0] e_fmax;
  } vec_t;

  int            n_checks = 0;
  int            n_fail   = 0;
  sb_t           q[$];
  logic [DW-1:0] fmax_seen[$];
  int            m_idx;
  int            m_size;
  logic [DW-1:0] m_run;
  logic [DW-1:0] m_fmax;
  logic          m_fmv;
  logic          m_ovf;
  vec_t          tbl [5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_idx = 0; m_size = 4; m_run = '0; m_fmax = '0; m_fmv = 1'b0; m_ovf = 1'b0;
  endtask

  // One clock cycle: drive, check head/count, update model, clock, check frame outputs.
  task automatic cycle(input logic iv, input logic [DW-1:0] val, input logic ms, input logic rdy);
    logic          pop;
    logic          lst;
    logic [DW-1:0] nm;
    sb_t           e;
    in_valid = iv; in_value = val; matrix_size = ms; out_ready = rdy;
    #1;
    check("out_valid", 64'(out_valid), 64'(q.size() != 0));
    if (q.size() != 0) begin
      check("out_data", 64'(out_data), 64'(q[0].data));
      check("out_last", 64'(out_last), 64'(q[0].last));
    end
    check("count", 64'(count), 64'(q.size()));
    pop = rdy && (q.size() != 0);
    lst = 1'b0;
    if (iv) begin
      if (m_idx == 0) m_size = ms ? 16 : 4;
      lst = (m_idx == m_size - 1);
      nm = (val > m_run) ? val : m_run;
      if (lst) begin
        m_fmax = nm; m_run = '0; m_idx = 0; m_fmv = 1'b1;
      end else begin
        m_run = nm; m_idx = m_idx + 1; m_fmv = 1'b0;
      end
    end else begin
      m_fmv = 1'b0;
    end
    if (pop) void'(q.pop_front());
    if (iv) begin
      if (q.size() < DEPTH) begin
        e.last = lst; e.data = val;
        q.push_back(e);
      end else begin
        m_ovf = 1'b1;
      end
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("frame_max_valid", 64'(frame_max_valid), 64'(m_fmv));
    check("frame_max", 64'(frame_max), 64'(m_fmax));
    check("overflow", 64'(overflow), 64'(m_ovf));
    if (frame_max_valid) fmax_seen.push_back(frame_max);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_out_data"}, 64'(out_data), 64'd0);
    check({tag, "_out_last"}, 64'(out_last), 64'd0);
    check({tag, "_frame_max"}, 64'(frame_max), 64'd0);
    check({tag, "_frame_max_valid"}, 64'(frame_max_valid), 64'd0);
    check({tag, "_overflow"}, 64'(overflow), 64'd0);
    check({tag, "_count"}, 64'(count), 64'd0);
  endtask

  // Called at a falling edge; reset takes effect without any clock edge.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    check_all_zero("rst");
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    fmax_seen.delete();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_value = '0; matrix_size = 1'b0; out_ready = 1'b0;
    model_reset();
    //            iv    val      ms    rdy   e_ov  e_data   e_last e_fmv e_fmax
    tbl[0] = '{1'b1, 40'd19, 1'b0, 1'b1, 1'b1, 40'd19, 1'b0, 1'b0, 40'd0};
    tbl[1] = '{1'b1, 40'd22, 1'b0, 1'b1, 1'b1, 40'd22, 1'b0, 1'b0, 40'd0};
    tbl[2] = '{1'b1, 40'd43, 1'b0, 1'b1, 1'b1, 40'd43, 1'b0, 1'b0, 40'd0};
    tbl[3] = '{1'b1, 40'd50, 1'b0, 1'b1, 1'b1, 40'd50, 1'b1, 1'b1, 40'd50};
    tbl[4] = '{1'b0, 40'd0,  1'b0, 1'b1, 1'b0, 40'd0,  1'b0, 1'b0, 40'd50};

    @(negedge clk);
    @(negedge clk);
    check_all_zero("init");
    rst = 1'b0;

    // Test 1: 2x2 frame streamed straight through.
    for (int i = 0; i < 5; i++) begin
      cycle(tbl[i].iv, tbl[i].val, tbl[i].ms, tbl[i].rdy);
      check("t1_out_valid", 64'(out_valid), 64'(tbl[i].e_ov));
      if (tbl[i].e_ov) begin
        check("t1_out_data", 64'(out_data), 64'(tbl[i].e_data));
        check("t1_out_last", 64'(out_last), 64'(tbl[i].e_last));
      end
      check("t1_fmv", 64'(frame_max_valid), 64'(tbl[i].e_fmv));
      check("t1_fmax", 64'(frame_max), 64'(tbl[i].e_fmax));
    end
    check("t1_overflow", 64'(overflow), 64'd0);
    do_reset();

    // Test 2: 4x4 frame into a stalled consumer, then drained.
    for (int i = 1; i <= 16; i++) cycle(1'b1, 40'(i), 1'b1, 1'b0);
    check("t2_count_full", 64'(count), 64'd16);
    check("t2_overflow", 64'(overflow), 64'd0);
    check("t2_fmax", 64'(frame_max), 64'd16);
    for (int i = 0; i < 16; i++) cycle(1'b0, 40'd0, 1'b0, 1'b1);
    check("t2_count_empty", 64'(count), 64'd0);
    do_reset();

    // Test 3: three frames into a stalled consumer; the tail of the 4x4 frame is dropped.
    for (int i = 1; i <= 8; i++) cycle(1'b1, 40'(i), 1'b0, 1'b0);
    for (int i = 9; i <= 24; i++) cycle(1'b1, 40'(i), 1'b1, 1'b0);
    check("t3_overflow", 64'(overflow), 64'd1);
    check("t3_count", 64'(count), 64'd16);
    check("t3_fmax_pulses", 64'(fmax_seen.size()), 64'd3);
    if (fmax_seen.size() == 3) begin
      check("t3_fmax0", 64'(fmax_seen[0]), 64'd4);
      check("t3_fmax1", 64'(fmax_seen[1]), 64'd8);
      check("t3_fmax2", 64'(fmax_seen[2]), 64'd24);
    end
    for (int i = 0; i < 16; i++) cycle(1'b0, 40'd0, 1'b0, 1'b1);
    check("t3_overflow_sticky", 64'(overflow), 64'd1);
    do_reset();

    // Test 4: push and pop together at full.
    for (int i = 1; i <= 16; i++) cycle(1'b1, 40'(i), 1'b1, 1'b0);
    for (int i = 101; i <= 104; i++) cycle(1'b1, 40'(i), 1'b0, 1'b1);
    check("t4_count", 64'(count), 64'd16);
    check("t4_overflow", 64'(overflow), 64'd0);
    check("t4_head", 64'(out_data), 64'd5);
    for (int i = 0; i < 16; i++) cycle(1'b0, 40'd0, 1'b0, 1'b1);
    do_reset();

    // Test 5: matrix_size changes mid-frame are ignored.
    cycle(1'b1, 40'd1, 1'b0, 1'b1);
    cycle(1'b1, 40'd2, 1'b0, 1'b1);
    cycle(1'b1, 40'd3, 1'b1, 1'b1);
    cycle(1'b1, 40'd4, 1'b1, 1'b1);
    check("t5_fmax_2x2", 64'(frame_max), 64'd4);
    for (int i = 0; i < 16; i++) cycle(1'b1, 40'(31 + i), (i == 0) ? 1'b1 : 1'b0, 1'b1);
    cycle(1'b0, 40'd0, 1'b0, 1'b1);
    check("t5_fmax_pulses", 64'(fmax_seen.size()), 64'd2);
    if (fmax_seen.size() == 2) check("t5_fmax_4x4", 64'(fmax_seen[1]), 64'd46);
    do_reset();

    // Test 6: reset in the middle of a frame, then a fresh 2x2 frame.
    cycle(1'b1, 40'd70, 1'b0, 1'b0);
    cycle(1'b1, 40'd80, 1'b0, 1'b0);
    do_reset();
    cycle(1'b1, 40'd7, 1'b0, 1'b1);
    cycle(1'b1, 40'd3, 1'b0, 1'b1);
    cycle(1'b1, 40'd9, 1'b0, 1'b1);
    cycle(1'b1, 40'd1, 1'b0, 1'b1);
    check("t6_fmax", 64'(frame_max), 64'd9);
    check("t6_fmv", 64'(frame_max_valid), 64'd1);
    check("t6_last", 64'(out_last), 64'd1);
    check("t6_data", 64'(out_data), 64'd1);
    cycle(1'b0, 40'd0, 1'b0, 1'b1);
    check("t6_empty", 64'(out_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
